// File: rtl/k_and_s_pkg.sv
// Shared types for the K-and-S sequencer: instruction decode values,
// state encodings and ALU operation codes.
package k_and_s_pkg;

    typedef enum logic [4:0] {
        I_NOP    = 5'd0,
        I_LOAD   = 5'd1,
        I_STORE  = 5'd2,
        I_MOVE   = 5'd3,
        I_ADD    = 5'd4,
        I_SUB    = 5'd5,
        I_AND    = 5'd6,
        I_OR     = 5'd7,
        I_BRANCH = 5'd8,
        I_BZERO  = 5'd9,
        I_BNZERO = 5'd10,
        I_BNEG   = 5'd11,
        I_BNNEG  = 5'd12,
        I_BOV    = 5'd13,
        I_BNOV   = 5'd14,
        I_HALT   = 5'd15
    } decoded_instruction_type;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE    = 4'd0;
    localparam state_t S_FETCH_W = 4'd1;
    localparam state_t S_FETCH   = 4'd2;
    localparam state_t S_DECODE  = 4'd3;
    localparam state_t S_MEM_W   = 4'd4;
    localparam state_t S_LOAD_WB = 4'd5;
    localparam state_t S_STORE   = 4'd6;
    localparam state_t S_EXEC    = 4'd7;
    localparam state_t S_BR_TAKE = 4'd8;
    localparam state_t S_HALTED  = 4'd9;

    localparam logic [1:0] OP_OR  = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    // Only meaningful for branch encodings; anything else reports not-taken.
    function automatic logic branch_taken(input decoded_instruction_type instr,
                                          input logic zero_op,
                                          input logic neg_op,
                                          input logic signed_overflow);
        case (instr)
            I_BRANCH: branch_taken = 1'b1;
            I_BZERO:  branch_taken = zero_op;
            I_BNZERO: branch_taken = ~zero_op;
            I_BNEG:   branch_taken = neg_op;
            I_BNNEG:  branch_taken = ~neg_op;
            I_BOV:    branch_taken = signed_overflow;
            I_BNOV:   branch_taken = ~signed_overflow;
            default:  branch_taken = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ks_sequencer_if.sv
// Control/status bundle between the sequencer (master) and the datapath/RAM (slave).
interface ks_sequencer_if #(parameter int CNT_W = 16);
    import k_and_s_pkg::*;

    decoded_instruction_type decoded_instruction;
    logic zero_op;
    logic neg_op;
    logic unsigned_overflow;
    logic signed_overflow;

    logic branch;
    logic pc_enable;
    logic ir_enable;
    logic write_reg_enable;
    logic addr_sel;
    logic c_sel;
    logic flags_reg_enable;
    logic ram_write_enable;
    logic halt;
    logic [1:0] operation;
    logic illegal_instr;
    logic [CNT_W-1:0] retired;

    modport master (
        input  decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
        output branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel,
               flags_reg_enable, ram_write_enable, halt, operation, illegal_instr, retired
    );

    modport slave (
        output decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
        input  branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel,
               flags_reg_enable, ram_write_enable, halt, operation, illegal_instr, retired
    );

endinterface

// File: rtl/ks_wait_counter.sv
// Down-counter for wait states: loaded on entry, done while the count is 1.
module ks_wait_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == WIDTH'(1));

endmodule

// File: rtl/ks_sequencer.sv
// Multi-cycle control FSM for the K-and-S processor: fetch, decode,
// load/store/ALU/branch execution, halt, and a retired-instruction counter.
module ks_sequencer
    import k_and_s_pkg::*;
#(
    parameter int MEM_WAIT   = 1,
    parameter int FETCH_WAIT = 0,
    parameter int CNT_W      = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    ks_sequencer_if.master bus
);

    state_t           state_q, state_d;
    logic [1:0]       exec_op_q, exec_op_d;
    logic             exec_flags_q, exec_flags_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic             retire;
    logic             wait_load;
    logic [3:0]       wait_value;
    logic             wait_done;
    state_t           fetch_next;

    logic             o_branch, o_pc_enable, o_ir_enable, o_write_reg_enable;
    logic             o_addr_sel, o_c_sel, o_flags_reg_enable, o_ram_write_enable, o_halt;
    logic [1:0]       o_operation;

    ks_wait_counter #(.WIDTH(4)) u_wait (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (wait_load),
        .load_value (wait_value),
        .done       (wait_done)
    );

    // Next state, retire pulse and Moore outputs; EXEC's op and flag enable
    // are captured in DECODE so outputs never depend on live inputs.
    always_comb begin
        state_d      = state_q;
        exec_op_d    = exec_op_q;
        exec_flags_d = exec_flags_q;
        illegal_d    = illegal_q;
        retire       = 1'b0;
        fetch_next   = (FETCH_WAIT > 0) ? S_FETCH_W : S_FETCH;

        o_branch           = 1'b0;
        o_pc_enable        = 1'b0;
        o_ir_enable        = 1'b0;
        o_write_reg_enable = 1'b0;
        o_addr_sel         = 1'b0;
        o_c_sel            = 1'b0;
        o_flags_reg_enable = 1'b0;
        o_ram_write_enable = 1'b0;
        o_halt             = 1'b0;
        o_operation        = OP_OR;

        case (state_q)
            S_IDLE:    state_d = fetch_next;
            S_FETCH_W: if (wait_done) state_d = S_FETCH;
            S_FETCH: begin
                o_ir_enable = 1'b1;
                o_pc_enable = 1'b1;
                state_d     = S_DECODE;
            end
            S_DECODE: begin
                case (bus.decoded_instruction)
                    I_NOP: begin
                        state_d = fetch_next;
                        retire  = 1'b1;
                    end
                    I_LOAD:  state_d = (MEM_WAIT > 0) ? S_MEM_W : S_LOAD_WB;
                    I_STORE: state_d = S_STORE;
                    I_MOVE: begin
                        state_d      = S_EXEC;
                        exec_op_d    = OP_OR;
                        exec_flags_d = 1'b0;
                    end
                    I_ADD, I_SUB, I_AND, I_OR: begin
                        state_d      = S_EXEC;
                        exec_flags_d = 1'b1;
                        case (bus.decoded_instruction)
                            I_ADD:   exec_op_d = OP_ADD;
                            I_SUB:   exec_op_d = OP_SUB;
                            I_AND:   exec_op_d = OP_AND;
                            default: exec_op_d = OP_OR;
                        endcase
                    end
                    I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV: begin
                        if (branch_taken(bus.decoded_instruction, bus.zero_op,
                                         bus.neg_op, bus.signed_overflow)) begin
                            state_d = S_BR_TAKE;
                        end else begin
                            state_d = fetch_next;
                            retire  = 1'b1;
                        end
                    end
                    I_HALT:  state_d = S_HALTED;
                    default: begin
                        state_d   = S_HALTED;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEM_W: begin
                o_addr_sel = 1'b1;
                if (wait_done) state_d = S_LOAD_WB;
            end
            S_LOAD_WB: begin
                o_addr_sel         = 1'b1;
                o_c_sel            = 1'b1;
                o_write_reg_enable = 1'b1;
                state_d            = fetch_next;
                retire             = 1'b1;
            end
            S_STORE: begin
                o_addr_sel         = 1'b1;
                o_ram_write_enable = 1'b1;
                state_d            = fetch_next;
                retire             = 1'b1;
            end
            S_EXEC: begin
                o_operation        = exec_op_q;
                o_write_reg_enable = 1'b1;
                o_flags_reg_enable = exec_flags_q;
                state_d            = fetch_next;
                retire             = 1'b1;
            end
            S_BR_TAKE: begin
                o_branch    = 1'b1;
                o_pc_enable = 1'b1;
                state_d     = fetch_next;
                retire      = 1'b1;
            end
            S_HALTED: o_halt = 1'b1;
            default:  state_d = S_IDLE;
        endcase

        wait_load  = ((state_d == S_FETCH_W) && (state_q != S_FETCH_W)) ||
                     ((state_d == S_MEM_W)   && (state_q != S_MEM_W));
        wait_value = (state_d == S_MEM_W) ? 4'(MEM_WAIT) : 4'(FETCH_WAIT);

        retired_d = retired_q;
        if (retire && (retired_q != {CNT_W{1'b1}})) begin
            retired_d = retired_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            exec_op_q    <= OP_OR;
            exec_flags_q <= 1'b0;
            illegal_q    <= 1'b0;
            retired_q    <= '0;
        end else begin
            state_q      <= state_d;
            exec_op_q    <= exec_op_d;
            exec_flags_q <= exec_flags_d;
            illegal_q    <= illegal_d;
            retired_q    <= retired_d;
        end
    end

    assign bus.branch           = o_branch;
    assign bus.pc_enable        = o_pc_enable;
    assign bus.ir_enable        = o_ir_enable;
    assign bus.write_reg_enable = o_write_reg_enable;
    assign bus.addr_sel         = o_addr_sel;
    assign bus.c_sel            = o_c_sel;
    assign bus.flags_reg_enable = o_flags_reg_enable;
    assign bus.ram_write_enable = o_ram_write_enable;
    assign bus.halt             = o_halt;
    assign bus.operation        = o_operation;
    assign bus.illegal_instr    = illegal_q;
    assign bus.retired          = retired_q;

endmodule

// File: tb/tb_ks_sequencer.sv
// Directed bench: three sequencer configurations driven one after another
// with hand-computed control patterns, counter values and wait-state timing.
module tb_ks_sequencer;
    import k_and_s_pkg::*;

    // Control bit order: {branch, pc_en, ir_en, wr_en, addr_sel, c_sel, flags_en, ram_we, halt, op[1:0]}
    localparam logic [10:0] C_NONE    = 11'b00000000000;
    localparam logic [10:0] C_FETCH   = 11'b01100000000;
    localparam logic [10:0] C_MEM_W   = 11'b00001000000;
    localparam logic [10:0] C_LOAD_WB = 11'b00011100000;
    localparam logic [10:0] C_STORE   = 11'b00001001000;
    localparam logic [10:0] C_SUB     = 11'b00010010010;
    localparam logic [10:0] C_MOVE    = 11'b00010000000;
    localparam logic [10:0] C_BR      = 11'b11000000000;
    localparam logic [10:0] C_HALT    = 11'b00000000100;

    logic clk;
    logic rst_n_a, rst_n_b, rst_n_c;
    int   total, bad;

    ks_sequencer_if #(.CNT_W(16)) bus_a ();
    ks_sequencer_if #(.CNT_W(16)) bus_b ();
    ks_sequencer_if #(.CNT_W(2))  bus_c ();

    ks_sequencer #(.MEM_WAIT(3), .FETCH_WAIT(0), .CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n_a), .bus(bus_a));
    ks_sequencer #(.MEM_WAIT(1), .FETCH_WAIT(2), .CNT_W(16)) dut_b (.clk(clk), .rst_n(rst_n_b), .bus(bus_b));
    ks_sequencer #(.MEM_WAIT(0), .FETCH_WAIT(0), .CNT_W(2))  dut_c (.clk(clk), .rst_n(rst_n_c), .bus(bus_c));

    logic [10:0] ctl_a, ctl_b, ctl_c;
    assign ctl_a = {bus_a.branch, bus_a.pc_enable, bus_a.ir_enable, bus_a.write_reg_enable, bus_a.addr_sel,
                    bus_a.c_sel, bus_a.flags_reg_enable, bus_a.ram_write_enable, bus_a.halt, bus_a.operation};
    assign ctl_b = {bus_b.branch, bus_b.pc_enable, bus_b.ir_enable, bus_b.write_reg_enable, bus_b.addr_sel,
                    bus_b.c_sel, bus_b.flags_reg_enable, bus_b.ram_write_enable, bus_b.halt, bus_b.operation};
    assign ctl_c = {bus_c.branch, bus_c.pc_enable, bus_c.ir_enable, bus_c.write_reg_enable, bus_c.addr_sel,
                    bus_c.c_sel, bus_c.flags_reg_enable, bus_c.ram_write_enable, bus_c.halt, bus_c.operation};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        int          cycles, addr_cnt, wr_cnt;
        logic        found;
        logic [10:0] lwb_ctl;
        logic [1:0]  exp_ret [5];

        total = 0;
        bad   = 0;
        rst_n_a = 1'b0; rst_n_b = 1'b0; rst_n_c = 1'b0;
        bus_a.decoded_instruction = I_NOP; bus_a.zero_op = 0; bus_a.neg_op = 0;
        bus_a.unsigned_overflow = 0; bus_a.signed_overflow = 0;
        bus_b.decoded_instruction = I_NOP; bus_b.zero_op = 0; bus_b.neg_op = 0;
        bus_b.unsigned_overflow = 0; bus_b.signed_overflow = 0;
        bus_c.decoded_instruction = I_NOP; bus_c.zero_op = 0; bus_c.neg_op = 0;
        bus_c.unsigned_overflow = 0; bus_c.signed_overflow = 0;
        tick();
        tick();

        check("a_reset_ctl", 32'(ctl_a), 32'(C_NONE));
        check("a_reset_retired", 32'(bus_a.retired), 32'd0);
        check("a_reset_illegal", 32'(bus_a.illegal_instr), 32'd0);

        // ---- config A: MEM_WAIT=3, LOAD then HALT
        bus_a.decoded_instruction = I_LOAD;
        rst_n_a = 1'b1;
        check("a_idle_ctl", 32'(ctl_a), 32'(C_NONE));
        tick();
        check("a_fetch1_ctl", 32'(ctl_a), 32'(C_FETCH));
        cycles = 0; addr_cnt = 0; wr_cnt = 0; found = 1'b0; lwb_ctl = '0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            cycles++;
            if (ctl_a[6]) begin
                addr_cnt++;
                bus_a.decoded_instruction = I_HALT;
            end
            if (ctl_a[7]) begin
                wr_cnt++;
                lwb_ctl = ctl_a;
            end
            if (ctl_a[8]) found = 1'b1;
        end
        check("a_load_next_fetch_seen", 32'(found), 32'd1);
        check("a_load_fetch_to_fetch", 32'(cycles), 32'd6);
        check("a_load_addr_cycles", 32'(addr_cnt), 32'd4);
        check("a_load_wr_pulses", 32'(wr_cnt), 32'd1);
        check("a_load_wb_ctl", 32'(lwb_ctl), 32'(C_LOAD_WB));
        check("a_load_retired", 32'(bus_a.retired), 32'd1);
        tick();
        tick();
        check("a_halt_ctl", 32'(ctl_a), 32'(C_HALT));
        check("a_halt_retired", 32'(bus_a.retired), 32'd1);
        check("a_halt_illegal", 32'(bus_a.illegal_instr), 32'd0);

        // ---- config A: reset pulsed during MEM_W
        rst_n_a = 1'b0;
        tick();
        bus_a.decoded_instruction = I_NOP;
        rst_n_a = 1'b1;
        tick();
        check("a2_fetch_ctl", 32'(ctl_a), 32'(C_FETCH));
        tick();
        tick();
        check("a2_nop_fetch_ctl", 32'(ctl_a), 32'(C_FETCH));
        check("a2_nop_retired", 32'(bus_a.retired), 32'd1);
        bus_a.decoded_instruction = I_LOAD;
        tick();
        tick();
        check("a2_mem_w_ctl", 32'(ctl_a), 32'(C_MEM_W));
        rst_n_a = 1'b0;
        #1;
        check("a2_async_rst_ctl", 32'(ctl_a), 32'(C_NONE));
        check("a2_async_rst_retired", 32'(bus_a.retired), 32'd0);
        tick();
        bus_a.decoded_instruction = I_MOVE;
        rst_n_a = 1'b1;
        check("a2_release_idle_ctl", 32'(ctl_a), 32'(C_NONE));
        tick();
        check("a2_release_fetch_ctl", 32'(ctl_a), 32'(C_FETCH));
        tick();
        tick();
        check("a2_move_exec_ctl", 32'(ctl_a), 32'(C_MOVE));
        tick();
        check("a2_move_retired", 32'(bus_a.retired), 32'd1);

        // ---- config B: FETCH_WAIT=2, taken BNEG, untaken BOV, LOAD
        rst_n_b = 1'b1;
        check("b_idle_ctl", 32'(ctl_b), 32'(C_NONE));
        tick();
        check("b_fetch_w1_ctl", 32'(ctl_b), 32'(C_NONE));
        tick();
        check("b_fetch_w2_ctl", 32'(ctl_b), 32'(C_NONE));
        tick();
        check("b_fetch_ctl", 32'(ctl_b), 32'(C_FETCH));
        bus_b.decoded_instruction = I_BNEG;
        bus_b.neg_op = 1'b1;
        tick();
        check("b_decode_ctl", 32'(ctl_b), 32'(C_NONE));
        tick();
        check("b_br_take_ctl", 32'(ctl_b), 32'(C_BR));
        bus_b.neg_op = 1'b0;
        tick();
        check("b_br_fw1_ctl", 32'(ctl_b), 32'(C_NONE));
        tick();
        check("b_br_fw2_ctl", 32'(ctl_b), 32'(C_NONE));
        tick();
        check("b_br_refetch_ctl", 32'(ctl_b), 32'(C_FETCH));
        check("b_br_retired", 32'(bus_b.retired), 32'd1);
        bus_b.decoded_instruction = I_BOV;
        bus_b.signed_overflow = 1'b0;
        bus_b.neg_op = 1'b1;
        tick();
        tick();
        check("b_bov_untaken_ctl", 32'(ctl_b), 32'(C_NONE));
        tick();
        tick();
        check("b_bov_refetch_ctl", 32'(ctl_b), 32'(C_FETCH));
        check("b_bov_retired", 32'(bus_b.retired), 32'd2);
        bus_b.decoded_instruction = I_LOAD;
        tick();
        tick();
        check("b_mem_w_ctl", 32'(ctl_b), 32'(C_MEM_W));
        tick();
        check("b_load_wb_ctl", 32'(ctl_b), 32'(C_LOAD_WB));
        tick();
        check("b_load_retired", 32'(bus_b.retired), 32'd3);

        // ---- config C: CNT_W=2 saturation, SUB/BNZERO, STORE, LOAD, illegal
        exp_ret = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        rst_n_c = 1'b1;
        tick();
        check("c_fetch_ctl", 32'(ctl_c), 32'(C_FETCH));
        for (int k = 0; k < 5; k++) begin
            tick();
            tick();
            check($sformatf("c_nop%0d_fetch_ctl", k), 32'(ctl_c), 32'(C_FETCH));
            check($sformatf("c_nop%0d_retired", k), 32'(bus_c.retired), 32'(exp_ret[k]));
        end
        rst_n_c = 1'b0;
        tick();
        check("c_rst_retired", 32'(bus_c.retired), 32'd0);
        bus_c.decoded_instruction = I_SUB;
        bus_c.zero_op = 1'b1;
        rst_n_c = 1'b1;
        tick();
        tick();
        tick();
        check("c_sub_exec_ctl", 32'(ctl_c), 32'(C_SUB));
        tick();
        bus_c.decoded_instruction = I_BNZERO;
        tick();
        check("c_bnzero_decode_ctl", 32'(ctl_c), 32'(C_NONE));
        tick();
        check("c_bnzero_refetch_ctl", 32'(ctl_c), 32'(C_FETCH));
        check("c_bnzero_retired", 32'(bus_c.retired), 32'd2);
        bus_c.decoded_instruction = I_STORE;
        tick();
        tick();
        check("c_store_ctl", 32'(ctl_c), 32'(C_STORE));
        tick();
        check("c_store_retired", 32'(bus_c.retired), 32'd3);
        bus_c.decoded_instruction = I_LOAD;
        tick();
        tick();
        check("c_load_wb_nowait_ctl", 32'(ctl_c), 32'(C_LOAD_WB));
        tick();
        check("c_load_fetch_ctl", 32'(ctl_c), 32'(C_FETCH));
        check("c_load_retired_sat", 32'(bus_c.retired), 32'd3);
        bus_c.decoded_instruction = decoded_instruction_type'(5'd20);
        tick();
        tick();
        for (int k = 0; k < 10; k++) begin
            check($sformatf("c_illegal%0d_ctl", k), 32'(ctl_c), 32'(C_HALT));
            check($sformatf("c_illegal%0d_flag", k), 32'(bus_c.illegal_instr), 32'd1);
            bus_c.decoded_instruction = decoded_instruction_type'(5'($urandom_range(0, 31)));
            bus_c.zero_op = 1'($urandom_range(0, 1));
            bus_c.neg_op = 1'($urandom_range(0, 1));
            bus_c.signed_overflow = 1'($urandom_range(0, 1));
            tick();
        end
        check("c_illegal_retired", 32'(bus_c.retired), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
